fsk_peak_demod: RTL and testbench

FSK_PEAK_DEMOD -- requirements
Module: fsk_peak_demod

---
 rtl/fsk_peak_demod_pkg.sv | 14 +
 rtl/fsk_peak_demod_peak_det.sv | 45 ++++
 rtl/fsk_peak_demod.sv | 116 +++++++++++
 tb/tb_fsk_peak_demod.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_peak_demod_pkg.sv
// Shared FSM state type and default parameter values for the FSK peak-count demodulator.
package fsk_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_SYM_LEN  = 32;
  localparam int DEF_PEAK_THR = 4;
  localparam int DEF_AMP_MIN  = 40;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fsk_peak_demod_peak_det.sv
// Local-maximum detector: tracks the previous sample and the slope direction, and pulses
// peak in the same cycle as a falling sample that follows a rise to at least AMP_MIN.
module fsk_peak_det
  import fsk_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AMP_MIN = DEF_AMP_MIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  output logic              peak
);

  localparam logic [DATA_W-1:0] AMP_MIN_V = DATA_W'(AMP_MIN);

  logic [DATA_W-1:0] prev;
  logic              slope;
  logic              primed;

  assign peak = valid && primed && slope && (sample < prev) && (prev >= AMP_MIN_V);

  // The first sample after a clear only loads prev; slope waits for a real difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      slope  <= 1'b0;
      primed <= 1'b0;
    end else if (clr) begin
      prev   <= '0;
      slope  <= 1'b0;
      primed <= 1'b0;
    end else if (valid) begin
      prev   <= sample;
      primed <= 1'b1;
      if (primed) begin
        if (sample > prev)      slope <= 1'b1;
        else if (sample < prev) slope <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsk_peak_demod.sv
// FSK demodulator: counts amplitude peaks per SYM_LEN-sample window and decides one bit per window.
// Optional statistics outputs (last_peak_cnt, sym_cnt) are built when FSK_DEMOD_STATS_EN is defined.
module fsk_peak_demod
  import fsk_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SYM_LEN  = DEF_SYM_LEN,
  parameter int PEAK_THR = DEF_PEAK_THR,
  parameter int AMP_MIN  = DEF_AMP_MIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         in_valid,
  output logic                         data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
`ifdef FSK_DEMOD_STATS_EN
  output logic [$clog2(SYM_LEN+1)-1:0] last_peak_cnt,
  output logic [15:0]                  sym_cnt,
`endif
  output logic                         busy
);

  localparam int CNT_W = $clog2(SYM_LEN + 1);
  localparam int IDX_W = $clog2(SYM_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SYM_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_LEN - 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept, abort, wrap, peak;

  assign accept = (state == RUN) && en && in_valid;
  assign abort  = (state == RUN) && !en;
  assign wrap   = accept && (idx == IDX_LAST);
  assign busy   = (state == RUN);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:    if (en)  state_nx = RUN;
      RUN:     if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (peak && (cnt != CNT_MAX)) cnt_nx = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  fsk_peak_det #(
    .DATA_W  (DATA_W),
    .AMP_MIN (AMP_MIN)
  ) u_peak_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (abort),
    .sample (data_in),
    .valid  (accept),
    .peak   (peak)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (abort) begin
      idx <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (wrap) begin
        idx <= '0;
        cnt <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
        cnt <= cnt_nx;
      end
    end
  end

  // Output handshake: a bit transfers on any rising edge where out_valid && out_ready.
  // A new decision wins over that transfer; deciding over an unaccepted bit sets overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (wrap) begin
      data_out  <= (32'(cnt_nx) >= PEAK_THR);
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FSK_DEMOD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_peak_cnt <= '0;
      sym_cnt       <= '0;
    end else if (wrap) begin
      last_peak_cnt <= cnt_nx;
      if (sym_cnt != 16'hFFFF) sym_cnt <= sym_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fsk_peak_demod.sv
// Self-checking bench for fsk_peak_demod: directed waveforms plus randomized traffic against
// a sample-history reference model.
module tb_fsk_peak_demod;

  localparam int DATA_W   = 8;
  localparam int SYM_LEN  = 32;
  localparam int PEAK_THR = 4;
  localparam int AMP_MIN  = 40;
  localparam int CNT_W    = $clog2(SYM_LEN + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              data_out, out_valid, overrun, busy;
`ifdef FSK_DEMOD_STATS_EN
  logic [CNT_W-1:0]  last_peak_cnt;
  logic [15:0]       sym_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit   m_run;
  int   hist[$];
  int   m_peaks, m_last, m_sym;
  bit   m_valid, m_ovr;
  logic [0:0] exp_q[$];

  fsk_peak_demod #(
    .DATA_W(DATA_W), .SYM_LEN(SYM_LEN), .PEAK_THR(PEAK_THR), .AMP_MIN(AMP_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .in_valid(in_valid),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
`ifdef FSK_DEMOD_STATS_EN
    .last_peak_cnt(last_peak_cnt), .sym_cnt(sym_cnt),
`endif
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; hist.delete(); m_peaks = 0; m_last = 0; m_sym = 0;
    m_valid = 0; m_ovr = 0; exp_q.delete();
  endtask

  // A sample is a peak when the most recent non-flat step in the history was upward,
  // it falls below the previous sample, and that previous sample reached AMP_MIN.
  function automatic bit is_peak(input int x);
    int n;
    bit up;
    n = hist.size();
    up = 0;
    if (n == 0) return 0;
    for (int k = n - 1; k >= 1; k--) begin
      if (hist[k] != hist[k-1]) begin
        up = hist[k] > hist[k-1];
        break;
      end
    end
    return up && (x < hist[n-1]) && (hist[n-1] >= AMP_MIN);
  endfunction

  // driver: applies one cycle of inputs, advances the model, checks outputs after the edge
  task automatic cycle(input bit e, input bit v, input int s, input bit r);
    bit dec;
    bit nb;
    dec = 0;
    nb  = 0;
    en = e; in_valid = v; data_in = DATA_W'(s); out_ready = r;
    @(posedge clk);
    if (m_run && !e) begin
      hist.delete();
      m_peaks = 0;
    end else if (m_run && v) begin
      if (is_peak(s)) m_peaks++;
      hist.push_back(s);
      if (hist.size() % SYM_LEN == 0) begin
        dec = 1;
        nb = (m_peaks >= PEAK_THR);
        m_last = m_peaks;
        m_peaks = 0;
        if (m_sym < 65535) m_sym++;
      end
    end
    if (dec) begin
      if (m_valid && !r) m_ovr = 1;
      exp_q.delete();
      exp_q.push_back(nb);
      m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
      void'(exp_q.pop_front());
    end
    m_run = e;
    #1;
    check_eq("busy", busy, m_run);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("overrun", overrun, m_ovr);
    if (m_valid) check_eq("data_out", data_out, exp_q[0]);
`ifdef FSK_DEMOD_STATS_EN
    check_eq("sym_cnt", sym_cnt, m_sym);
    if (m_sym != 0) check_eq("last_peak_cnt", last_peak_cnt, m_last);
`endif
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    en = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int tone4(input int i, input int amp);
    case (i % 4)
      0:       return 0;
      2:       return amp;
      default: return amp / 2;
    endcase
  endfunction

  function automatic int tri16(input int i);
    int p;
    p = i % 16;
    return (p <= 8) ? 25 * p : 25 * (16 - p);
  endfunction

  initial begin
    int mode, walk, s;
    model_reset();
    #2;
    check_eq("init_data_out", data_out, 0);
    check_eq("init_out_valid", out_valid, 0);
    check_eq("init_overrun", overrun, 0);
    check_eq("init_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // period-4 tone at full amplitude: 8 peaks -> 1
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 31; i++) cycle(1, 1, tone4(i, 200), 0);
    check_eq("t4_early_valid", out_valid, 0);
    cycle(1, 1, tone4(31, 200), 0);
    check_eq("t4_valid", out_valid, 1);
    check_eq("t4_bit", data_out, 1);
    cycle(1, 0, 0, 1);

    // period-16 triangle: 2 peaks -> 0
    for (int i = 0; i < 32; i++) cycle(1, 1, tri16(i), 0);
    check_eq("tri_valid", out_valid, 1);
    check_eq("tri_bit", data_out, 0);
    cycle(1, 0, 0, 1);

    // low-amplitude tone: no peak reaches AMP_MIN -> 0
    for (int i = 0; i < 32; i++) cycle(1, 1, tone4(i, 30), 0);
    check_eq("low_amp_bit", data_out, 0);
    cycle(1, 0, 0, 1);

    // two windows without consumption -> overrun, second bit held
    for (int i = 0; i < 32; i++) cycle(1, 1, tone4(i, 30), 0);
    for (int i = 0; i < 32; i++) cycle(1, 1, tone4(i, 200), 0);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_bit", data_out, 1);
    check_eq("ovr_valid", out_valid, 1);
    cycle(1, 0, 0, 1);

    // abort after 10 samples, re-enter: decision 32 samples after re-entry
    for (int i = 0; i < 10; i++) cycle(1, 1, tone4(i, 200), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      check_eq("abort_busy", busy, 0);
    end
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 31; i++) cycle(1, 1, tone4(i, 200), 1);
    check_eq("reentry_early", out_valid, 0);
    cycle(1, 1, tone4(31, 200), 1);
    check_eq("reentry_valid", out_valid, 1);
    check_eq("reentry_bit", data_out, 1);

    // randomized traffic
    mode = 0;
    walk = 100;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: s = $urandom_range(0, 255);
        1: s = $urandom_range(0, 45);
        default: begin
          walk = walk + $urandom_range(0, 60) - 30;
          if (walk < 0) walk = 0;
          if (walk > 255) walk = 255;
          s = walk;
        end
      endcase
      cycle(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0), s,
            ($urandom_range(0, 1) == 1));
    end

    // reset mid-window while a bit is pending
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) cycle(1, 1, tone4(i, 200), 0);
    for (int i = 0; i < 7; i++) cycle(1, 1, tone4(i, 200), 0);
    check_eq("pre_rst_valid", out_valid, 1);
    do_reset();
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 32; i++) cycle(1, 1, tone4(i, 200), 1);
    check_eq("post_rst_bit", data_out, 1);
    cycle(1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
